spi1_cmd_target: RTL and testbench
==================================

// Module: spi1_cmd_target
// PURPOSE
// SPI1 target that turns MCU command frames into FPGA bus transactions and CPU control updates.
// It sits between the MCU SPI1 pins and the bus arbiter in top.
// It oversamples SCK in the system clock domain, deserialises opcode, address and data bytes,
// and issues one bus request per command. It returns read data to the MCU on the next frame.
// PARAMETERS
// CLK_MHZ   16  system clock frequency; SCK must not exceed CLK_MHZ/4
// ADDR_W    17  bus address width (bit 16 selects the upper 64K bank)
// PORTS
// clk_i            in   1   system clock (clk16)
// reset_i          in   1   asynchronous, active-high reset
// spi_sck_i        in   1   SPI1 clock, mode 0, asynchronous to clk_i
// spi_cs_ni        in   1   SPI1 chip select, active low
// spi_pico_i       in   1   MCU TX, sampled on SCK rising edge, MSB first
// spi_poci_o       out  1   MCU RX, changes after SCK falling edge, MSB first
// spi_poci_oe      out  1   1 only while spi_cs_ni is low (synchronised)
// spi_ready_no     out  1   0 = idle and ready for a frame; 1 = command pending or bus access busy
// bus_addr_o       out  17  transaction address
// bus_data_o       out  8   write data
// bus_data_i       in   8   read data, valid when bus_done_i=1
// bus_rw_no        out  1   1 = read, 0 = write
// bus_req_o        out  1   request, held until bus_done_i
// bus_done_i       in   1   single-cycle acknowledge from the arbiter
// cpu_reset_o      out  1   1 = hold 6502 in reset
// cpu_ready_o      out  1   1 = CPU RDY asserted
// BEHAVIOUR
// - Reset values: spi_poci_o=0, spi_poci_oe=0, spi_ready_no=0, bus_req_o=0, bus_rw_no=1, bus_addr_o=0,
//   bus_data_o=0, cpu_reset_o=1, cpu_ready_o=0. Read buffer and address register clear to 0.
// - Input synchronisation: SCK, CS_N and PICO pass through 2-FF synchronisers.
//   Edges are detected from sync stages 2 and 3, so edge-to-action latency is 3 clk_i cycles max.
// - Frame start: CS_N falling clears the bit counter and byte index and loads the read buffer into the TX shift register.
//   spi_poci_o presents bit 7 before the first SCK rise.
// - Byte 0 is the opcode. op[7:5] selects the command; op[0] supplies addr[16] for *_AT commands.
//     000 READ_AT     + addr_hi, addr_lo       -> read at {op[0],hi,lo}
//     001 READ_NEXT   (no operands)            -> read at current address
//     010 WRITE_AT    + addr_hi, addr_lo, data -> write data at {op[0],hi,lo}
//     011 WRITE_NEXT  + data                   -> write at current address
//     100 SET_CPU     op[1]=reset, op[0]=ready -> update cpu_* on the cycle after byte complete; no bus access
//     others: ignored, spi_ready_no stays 0
// - FSM: IDLE -> RECV (CS low) -> REQ (last byte complete) -> IDLE (bus_done_i).
//   SET_CPU and unknown opcodes go RECV -> IDLE.
// - spi_ready_no rises the cycle after the final operand bit is sampled and falls the cycle after bus_done_i.
//   MCU must not start a new frame while it is 1.
// - REQ: bus_req_o=1 with stable addr/data/rw until bus_done_i. On done, a read latches bus_data_i into the read buffer.
//   After every access the address increments by 1 and wraps 0x1FFFF -> 0x00000.
// - Bytes received beyond the command length are ignored. POCI shifts out 0 after the first byte.
// - CS_N rising before the command is complete aborts the frame: no bus access, no CPU update, FSM -> IDLE.
//   CS_N rising during REQ does not cancel the request.
// - bus_done_i outside REQ is ignored. reset_i mid-transaction drops bus_req_o immediately (asynchronous).
// TESTING
// - Reset -> cpu_reset_o=1, cpu_ready_o=0, spi_ready_no=0, bus_req_o=0, spi_poci_oe=0.
// - Frame 0x80|0b10 (SET_CPU reset=1, ready=0), then 0x81 -> cpu_reset_o=0, cpu_ready_o=1; bus_req_o never set.
// - WRITE_AT 0x41,0x80,0x00,0xA5 -> one req: addr=0x18000, rw_no=0, data=0xA5; ready_no 1 until done;
//   then WRITE_NEXT 0x60,0x5A -> addr=0x18001, data 0x5A.
// - READ_AT 0x00,0xFF,0xFF with bus_data_i=0x3C -> addr 0x0FFFF; next frame first byte on POCI = 0x3C;
//   READ_NEXT then -> addr 0x10000.
// - Address wrap: READ_AT 0x01,0xFF,0xFF then READ_NEXT -> second req at addr 0x00000.
// - Abort: WRITE_AT with CS_N raised after addr_lo -> no bus_req_o, spi_ready_no=0; next valid frame executes normally.

Source files
------------

// File: rtl/spi1_cmd_target.sv
// SPI1 command target: oversamples the MCU SPI1 frame in clk_i, decodes opcode/operands
// and issues one bus transaction or CPU control update per frame.
//
// state | meaning
// IDLE  | waiting for CS_N falling edge
// RECV  | shifting opcode and operand bytes
// REQ   | bus_req_o held until bus_done_i
module spi1_cmd_target #(
  parameter int CLK_MHZ = 16,
  parameter int ADDR_W  = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              spi_sck_i,
  input  logic              spi_cs_ni,
  input  logic              spi_pico_i,
  output logic              spi_poci_o,
  output logic              spi_poci_oe,
  output logic              spi_ready_no,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [7:0]        bus_data_o,
  input  logic [7:0]        bus_data_i,
  output logic              bus_rw_no,
  output logic              bus_req_o,
  input  logic              bus_done_i,
  output logic              cpu_reset_o,
  output logic              cpu_ready_o
);

  if (CLK_MHZ < 4) begin : g_clk_chk
    $error("spi1_cmd_target: CLK_MHZ must allow SCK <= CLK_MHZ/4");
  end

  typedef enum logic [1:0] {IDLE, RECV, REQ} state_t;

  state_t state_q, state_d;

  logic [2:0] sck_s, cs_s;
  logic [1:0] pico_s;
  logic [2:0] bit_cnt;
  logic [1:0] byte_idx;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [7:0] rd_buf;
  logic [2:0] cmd_r;
  logic       op0_r;
  logic [7:0] hi_r, lo_r;
  logic [ADDR_W-1:0] addr_r;
  logic       rw_no_r;
  logic [7:0] wdata_r;
  logic       cpu_reset_r, cpu_ready_r, poci_oe_r;

  logic       sck_rise, sck_fall, cs_fall, cs_rise, byte_done;
  logic [7:0] rx_byte;
  logic [2:0] cur_cmd;
  logic       complete, issue, set_cpu;

  assign sck_rise  = sck_s[1] & ~sck_s[2];
  assign sck_fall  = ~sck_s[1] & sck_s[2];
  assign cs_fall   = ~cs_s[1] & cs_s[2];
  assign cs_rise   = cs_s[1] & ~cs_s[2];
  assign rx_byte   = {rx_shift, pico_s[1]};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  // the opcode is not yet stored while its own last bit is being sampled
  assign cur_cmd   = (byte_idx == 2'd0) ? rx_byte[7:5] : cmd_r;

  function automatic logic [1:0] cmd_len(input logic [2:0] cmd);
    case (cmd)
      3'b000:  cmd_len = 2'd2;
      3'b010:  cmd_len = 2'd3;
      3'b011:  cmd_len = 2'd1;
      default: cmd_len = 2'd0;
    endcase
  endfunction

  assign complete = (state_q == RECV) && byte_done && !cs_rise && (byte_idx == cmd_len(cur_cmd));
  assign issue    = complete && !cur_cmd[2];
  assign set_cpu  = complete && (cur_cmd == 3'b100);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cs_fall) state_d = RECV;
      RECV: begin
        if (cs_rise)       state_d = IDLE;
        else if (complete) state_d = issue ? REQ : IDLE;
      end
      REQ:  if (bus_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sck_s       <= 3'b000;
      cs_s        <= 3'b111;
      pico_s      <= 2'b00;
      bit_cnt     <= 3'd0;
      byte_idx    <= 2'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= 8'd0;
      rd_buf      <= 8'd0;
      cmd_r       <= 3'd0;
      op0_r       <= 1'b0;
      hi_r        <= 8'd0;
      lo_r        <= 8'd0;
      addr_r      <= '0;
      rw_no_r     <= 1'b1;
      wdata_r     <= 8'd0;
      cpu_reset_r <= 1'b1;
      cpu_ready_r <= 1'b0;
      poci_oe_r   <= 1'b0;
    end else begin
      sck_s     <= {sck_s[1:0], spi_sck_i};
      cs_s      <= {cs_s[1:0], spi_cs_ni};
      pico_s    <= {pico_s[0], spi_pico_i};
      poci_oe_r <= ~cs_s[1];

      if (cs_fall) begin
        bit_cnt  <= 3'd0;
        byte_idx <= 2'd0;
        tx_shift <= rd_buf;
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_idx <= byte_idx + 2'd1;
        end
        // zeros fill behind the read byte, so POCI idles low after byte 0
        if (sck_fall && !cs_s[1]) tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (state_q == RECV && byte_done) begin
        case (byte_idx)
          2'd0: begin cmd_r <= rx_byte[7:5]; op0_r <= rx_byte[0]; end
          2'd1: hi_r <= rx_byte;
          2'd2: lo_r <= rx_byte;
          default: ;
        endcase
      end

      if (issue) begin
        rw_no_r <= ~cur_cmd[1];
        if (!cur_cmd[0])
          addr_r <= ADDR_W'(cur_cmd[1] ? {op0_r, hi_r, lo_r} : {op0_r, hi_r, rx_byte});
        if (cur_cmd[1]) wdata_r <= rx_byte;
      end

      if (set_cpu) begin
        cpu_reset_r <= rx_byte[1];
        cpu_ready_r <= rx_byte[0];
      end

      if (state_q == REQ && bus_done_i) begin
        if (rw_no_r) rd_buf <= bus_data_i;
        addr_r <= addr_r + ADDR_W'(1);
      end
    end
  end

  assign spi_poci_o   = tx_shift[7];
  assign spi_poci_oe  = poci_oe_r;
  assign spi_ready_no = (state_q == REQ);
  assign bus_req_o    = (state_q == REQ);
  assign bus_addr_o   = addr_r;
  assign bus_data_o   = wdata_r;
  assign bus_rw_no    = rw_no_r;
  assign cpu_reset_o  = cpu_reset_r;
  assign cpu_ready_o  = cpu_ready_r;

endmodule

// File: tb/tb_spi1_cmd_target.sv
// Scoreboard bench for spi1_cmd_target: frames push expected bus transactions,
// an arbiter-side monitor pops and compares each request, then acknowledges it.
module tb_spi1_cmd_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, cs_n, pico;
  logic        poci, poci_oe, ready_no;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_rw_no, bus_req, bus_done;
  logic        cpu_reset, cpu_ready;

  always #5 clk = ~clk;

  spi1_cmd_target #(.CLK_MHZ(16), .ADDR_W(17)) dut (
    .clk_i(clk), .reset_i(rst),
    .spi_sck_i(sck), .spi_cs_ni(cs_n), .spi_pico_i(pico),
    .spi_poci_o(poci), .spi_poci_oe(poci_oe), .spi_ready_no(ready_no),
    .bus_addr_o(bus_addr), .bus_data_o(bus_wdata), .bus_data_i(bus_rdata),
    .bus_rw_no(bus_rw_no), .bus_req_o(bus_req), .bus_done_i(bus_done),
    .cpu_reset_o(cpu_reset), .cpu_ready_o(cpu_ready)
  );

  typedef struct {
    logic [16:0] addr;
    logic        rw_no;
    logic [7:0]  data;   // write data, or read data returned by the arbiter
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   req_cnt = 0;
  logic [7:0] txb[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [16:0] a, input logic rw, input logic [7:0] d);
    exp_t e;
    e.addr = a; e.rw_no = rw; e.data = d;
    exp_q.push_back(e);
  endtask

  // Arbiter model and monitor
  initial begin
    exp_t e;
    logic [16:0] a0;
    bus_done  = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_req", 32'(bus_addr), 32'hFFFFFFFF);
          e.addr = bus_addr; e.rw_no = 1'b1; e.data = 8'h00;
        end else begin
          e = exp_q.pop_front();
          chk("req_addr", 32'(bus_addr), 32'(e.addr));
          chk("req_rw_no", 32'(bus_rw_no), 32'(e.rw_no));
          if (!e.rw_no) chk("req_wdata", 32'(bus_wdata), 32'(e.data));
          chk("ready_no_busy", 32'(ready_no), 32'd1);
        end
        a0 = bus_addr;
        bus_rdata = e.data;
        repeat (2) @(negedge clk);
        chk("req_held", {14'd0, bus_req, bus_addr}, {14'd0, 1'b1, a0});
        bus_done = 1'b1;
        @(negedge clk);
        bus_done  = 1'b0;
        bus_rdata = 8'h00;
        chk("req_drop_after_done", {30'd0, bus_req, ready_no}, 32'd0);
      end
    end
  end

  task automatic frame(input int n, output logic [7:0] rx0, output logic [7:0] rx1);
    logic [7:0] rx;
    rx0 = 8'hEE; rx1 = 8'hEE;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    chk("poci_oe_active", 32'(poci_oe), 32'd1);
    for (int i = 0; i < n; i++) begin
      rx = 8'h00;
      for (int j = 7; j >= 0; j--) begin
        pico = txb[i][j];
        repeat (5) @(negedge clk);
        sck = 1'b1;
        rx  = {rx[6:0], poci};
        repeat (5) @(negedge clk);
        sck = 1'b0;
      end
      if (i == 0) rx0 = rx;
      if (i == 1) rx1 = rx;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("poci_oe_idle", 32'(poci_oe), 32'd0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 200; i++) begin
      if (!ready_no && !bus_req) break;
      @(negedge clk);
    end
    chk("wait_idle", {30'd0, ready_no, bus_req}, 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    rst = 1'b1; sck = 1'b0; cs_n = 1'b1; pico = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_ready_no", 32'(ready_no), 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_poci", {30'd0, poci_oe, poci}, 32'd0);
    chk("rst_bus", {6'd0, bus_rw_no, bus_addr, bus_wdata}, {6'd0, 1'b1, 17'd0, 8'd0});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    txb[0] = 8'h82; frame(1, r0, r1); wait_idle();
    chk("setcpu_82", {30'd0, cpu_reset, cpu_ready}, 32'b10);
    txb[0] = 8'h81; frame(1, r0, r1); wait_idle();
    chk("setcpu_81", {30'd0, cpu_reset, cpu_ready}, 32'b01);
    chk("setcpu_no_req", 32'(req_cnt), 32'd0);

    push(17'h18000, 1'b0, 8'hA5);
    txb = '{8'h41, 8'h80, 8'h00, 8'hA5}; frame(4, r0, r1); wait_idle();
    push(17'h18001, 1'b0, 8'h5A);
    txb[0] = 8'h60; txb[1] = 8'h5A; frame(2, r0, r1); wait_idle();

    push(17'h0FFFF, 1'b1, 8'h3C);
    txb[0] = 8'h00; txb[1] = 8'hFF; txb[2] = 8'hFF; frame(3, r0, r1); wait_idle();
    push(17'h10000, 1'b1, 8'h77);
    txb[0] = 8'h20; txb[1] = 8'h00; frame(2, r0, r1); wait_idle();
    chk("poci_read_3c", 32'(r0), 32'h3C);
    chk("poci_zero_after", 32'(r1), 32'h00);

    push(17'h1FFFF, 1'b1, 8'h11);
    txb[0] = 8'h01; txb[1] = 8'hFF; txb[2] = 8'hFF; frame(3, r0, r1); wait_idle();
    chk("poci_read_77", 32'(r0), 32'h77);
    push(17'h00000, 1'b1, 8'hC3);
    txb[0] = 8'h20; frame(1, r0, r1); wait_idle();
    chk("poci_read_11", 32'(r0), 32'h11);

    txb[0] = 8'hE0; frame(1, r0, r1);
    chk("unknown_ready_no", 32'(ready_no), 32'd0);
    chk("unknown_cpu", {30'd0, cpu_reset, cpu_ready}, 32'b01);

    txb[0] = 8'h42; txb[1] = 8'h12; txb[2] = 8'h34; frame(3, r0, r1);
    chk("abort_ready_no", 32'(ready_no), 32'd0);
    chk("abort_no_req", 32'(req_cnt), 32'd6);

    push(17'h00001, 1'b0, 8'h99);
    txb[0] = 8'h60; txb[1] = 8'h99; frame(2, r0, r1); wait_idle();
    chk("poci_read_c3", 32'(r0), 32'hC3);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("total_reqs", 32'(req_cnt), 32'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
